i2c_target: RTL and testbench

- Byte-level I2C target (slave) that answers the bus driven by the team's I2C master and clock generator. Exposes the temp-sensor datapath on the bus.
- Oversamples SCL/SDA on the system clock and detects START, STOP and repeated START.
- Matches a fixed 7-bit address and ACKs it.
- Delivers written bytes on a valid strobe; requests and shifts out bytes for reads.
- Drives SDA as open-drain only. The block never drives SCL; clock stretching is not supported.

---
 rtl/i2c_target.sv | 185 ++++++++++++++++++
 tb/tb_i2c_target.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_target.sv
// Byte-level I2C target: filtered SCL/SDA, START/STOP detection, fixed address, open-drain SDA.
// Define I2C_TARGET_GENCALL_EN to also accept the general-call address (7'h00, write only).

module i2c_target #(
  parameter logic [6:0] ADDR     = 7'h48,
  parameter int         FILT_LEN = 3
) (
  input  logic       in_clock,
  input  logic       reset,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_req,
  output logic       busy
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_ADDR, ST_ADDR_ACK, ST_RX, ST_RX_ACK, ST_TX, ST_TX_ACK, ST_IGNORE
  } state_t;

  localparam logic [2:0] FILT_MAX = 3'(FILT_LEN - 1);

  logic [1:0]      sync_p0, sync_p1, filt_p2, filt_p3;
  logic [1:0][2:0] fcnt;

  // stage p0/p1: synchronizer; p2: glitch filter; p3: previous filtered level for edges
  always_ff @(posedge in_clock) begin
    if (reset) begin
      sync_p0 <= 2'b11;
      sync_p1 <= 2'b11;
      filt_p2 <= 2'b11;
      filt_p3 <= 2'b11;
      fcnt    <= '0;
    end else begin
      sync_p0 <= {sda_in, scl_in};
      sync_p1 <= sync_p0;
      filt_p3 <= filt_p2;
      for (int i = 0; i < 2; i++) begin
        if (sync_p1[i] == filt_p2[i]) begin
          fcnt[i] <= 3'd0;
        end else if (fcnt[i] == FILT_MAX) begin
          filt_p2[i] <= sync_p1[i];
          fcnt[i]    <= 3'd0;
        end else begin
          fcnt[i] <= fcnt[i] + 3'd1;
        end
      end
    end
  end

  logic scl_f, sda_f, scl_rise, scl_fall, start, stop;
  assign scl_f    = filt_p2[0];
  assign sda_f    = filt_p2[1];
  assign scl_rise = scl_f & ~filt_p3[0];
  assign scl_fall = ~scl_f & filt_p3[0];
  assign start    = scl_f & filt_p3[0] & filt_p3[1] & ~sda_f;
  assign stop     = scl_f & filt_p3[0] & ~filt_p3[1] & sda_f;

  state_t     state, state_n;
  logic [2:0] cnt, cnt_n;
  logic [7:0] shift, shift_n, rx_data_n;
  logic       sda_oe_n, rx_valid_n, tx_req_n, busy_n, rw, rw_n;
  logic [7:0] byte_in;
  logic       gc_hit;

  assign byte_in = {shift[6:0], sda_f};

`ifdef I2C_TARGET_GENCALL_EN
  assign gc_hit = (byte_in == 8'h00);
`else
  assign gc_hit = 1'b0;
`endif

  always_ff @(posedge in_clock) begin
    if (reset) begin
      state    <= ST_IDLE;
      cnt      <= 3'd0;
      sda_oe   <= 1'b0;
      rx_data  <= 8'h00;
      rx_valid <= 1'b0;
      tx_req   <= 1'b0;
      busy     <= 1'b0;
      rw       <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      sda_oe   <= sda_oe_n;
      rx_data  <= rx_data_n;
      rx_valid <= rx_valid_n;
      tx_req   <= tx_req_n;
      busy     <= busy_n;
      rw       <= rw_n;
    end
  end

  always_ff @(posedge in_clock) begin
    shift <= shift_n;
  end

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    shift_n    = shift;
    sda_oe_n   = sda_oe;
    rx_data_n  = rx_data;
    rx_valid_n = 1'b0;
    tx_req_n   = 1'b0;
    busy_n     = busy;
    rw_n       = rw;
    if (stop) begin
      state_n  = ST_IDLE;
      cnt_n    = 3'd0;
      sda_oe_n = 1'b0;
      busy_n   = 1'b0;
    end else if (start) begin
      state_n  = ST_ADDR;
      cnt_n    = 3'd0;
      sda_oe_n = 1'b0;
    end else begin
      case (state)
        ST_ADDR: if (scl_rise) begin
          shift_n = byte_in;
          cnt_n   = cnt + 3'd1;
          if (cnt == 3'd7) begin
            if (byte_in[7:1] == ADDR || gc_hit) begin
              busy_n   = 1'b1;
              rw_n     = byte_in[0];
              tx_req_n = byte_in[0];
              state_n  = ST_ADDR_ACK;
            end else begin
              state_n = ST_IGNORE;
            end
          end
        end
        // first falling edge starts the ACK, the second one ends it
        ST_ADDR_ACK, ST_RX_ACK: if (scl_fall) begin
          if (!sda_oe) begin
            sda_oe_n = 1'b1;
          end else if (rw) begin
            state_n  = ST_TX;
            shift_n  = tx_data;
            sda_oe_n = ~tx_data[7];
          end else begin
            state_n  = ST_RX;
            sda_oe_n = 1'b0;
          end
        end
        ST_RX: if (scl_rise) begin
          shift_n = byte_in;
          cnt_n   = cnt + 3'd1;
          if (cnt == 3'd7) begin
            rx_data_n  = byte_in;
            rx_valid_n = 1'b1;
            state_n    = ST_RX_ACK;
          end
        end
        ST_TX: if (scl_rise) begin
          cnt_n = cnt + 3'd1;
        end else if (scl_fall) begin
          if (cnt == 3'd0) begin
            sda_oe_n = 1'b0;
            state_n  = ST_TX_ACK;
          end else begin
            sda_oe_n = ~shift[6];
            shift_n  = {shift[6:0], 1'b0};
          end
        end
        ST_TX_ACK: if (scl_rise) begin
          if (!sda_f) tx_req_n = 1'b1;
          else        state_n  = ST_IGNORE;
        end else if (scl_fall) begin
          state_n  = ST_TX;
          shift_n  = tx_data;
          sda_oe_n = ~tx_data[7];
        end
        ST_IGNORE: sda_oe_n = 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_target.sv
// Self-checking bench for i2c_target: bus-level master tasks, randomized payloads,
// expectations derived from transaction-level rules (who ACKs, which bytes arrive).

module tb_i2c_target;

  localparam logic [6:0] ADDR = 7'h48;
  localparam int Q = 10;

  logic       in_clock = 1'b0;
  logic       reset = 1'b1;
  logic       scl = 1'b1;
  logic       m_sda = 1'b1;
  logic       sda_oe, rx_valid, tx_req, busy;
  logic [7:0] rx_data;
  logic [7:0] tx_data = 8'h00;
  logic       sda_line;

  assign sda_line = m_sda & ~sda_oe;

  i2c_target #(.ADDR(ADDR), .FILT_LEN(3)) dut (
    .in_clock(in_clock), .reset(reset), .scl_in(scl), .sda_in(sda_line),
    .sda_oe(sda_oe), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_req(tx_req), .busy(busy)
  );

  always #5 in_clock = ~in_clock;

  int passed = 0;
  int total = 0;
  int rx_cnt = 0;
  int txr_cnt = 0;
  int oe_cnt = 0;
  logic [7:0] rx_log [256];
  logic [7:0] tx_src [256];

  always @(negedge in_clock) begin
    if (rx_valid) begin
      rx_log[rx_cnt[7:0]] = rx_data;
      rx_cnt++;
    end
    if (tx_req) begin
      tx_data = tx_src[txr_cnt[7:0]];
      txr_cnt++;
    end
    if (sda_oe) oe_cnt++;
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge in_clock);
  endtask

  task automatic bus_start();
    m_sda = 1'b1; wait_cyc(Q);
    scl = 1'b1;   wait_cyc(Q);
    m_sda = 1'b0; wait_cyc(Q);
    scl = 1'b0;   wait_cyc(Q);
  endtask

  task automatic bus_stop();
    m_sda = 1'b0; wait_cyc(Q);
    scl = 1'b1;   wait_cyc(Q);
    m_sda = 1'b1; wait_cyc(2 * Q);
  endtask

  task automatic clock_bit(input logic b, input logic glitch, output logic r);
    m_sda = b; wait_cyc(Q);
    scl = 1'b1; wait_cyc(Q / 2);
    if (glitch) begin
      scl = 1'b0; wait_cyc(1);
      scl = 1'b1;
    end
    wait_cyc(Q / 2);
    r = sda_line;
    wait_cyc(Q);
    scl = 1'b0; wait_cyc(Q);
  endtask

  task automatic write_byte(input logic [7:0] v, input int glitch_bit, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) clock_bit(v[i], i == glitch_bit, r);
    clock_bit(1'b1, 1'b0, r);
    ack = ~r;
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] d);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      clock_bit(1'b1, 1'b0, r);
      d[i] = r;
    end
    clock_bit(nack, 1'b0, r);
  endtask

  task automatic test_reset();
    reset = 1'b1; scl = 1'b1; m_sda = 1'b1;
    wait_cyc(5);
    reset = 1'b0;
    wait_cyc(10);
    total++; if (sda_oe !== 1'b0) $display("FAIL reset_sda_oe: got %b want 0", sda_oe); else passed++;
    total++; if (rx_data !== 8'h00) $display("FAIL reset_rx_data: got %h want 00", rx_data); else passed++;
    total++; if (rx_valid !== 1'b0) $display("FAIL reset_rx_valid: got %b want 0", rx_valid); else passed++;
    total++; if (tx_req !== 1'b0) $display("FAIL reset_tx_req: got %b want 0", tx_req); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passed++;
  endtask

  task automatic test_write();
    logic [7:0] d [4];
    int n, base;
    logic ack;
    for (int rep = 0; rep < 3; rep++) begin
      if (rep == 0) begin
        n = 2; d[0] = 8'hA5; d[1] = 8'h3C;
      end else begin
        n = int'($urandom_range(1, 4));
        for (int i = 0; i < 4; i++) d[i] = 8'($urandom);
      end
      base = rx_cnt;
      bus_start();
      write_byte({ADDR, 1'b0}, -1, ack);
      total++; if (ack !== 1'b1) $display("FAIL wr_addr_ack: got %b want 1", ack); else passed++;
      for (int i = 0; i < n; i++) begin
        write_byte(d[i], -1, ack);
        total++; if (ack !== 1'b1) $display("FAIL wr_data_ack: byte %0d got %b want 1", i, ack); else passed++;
      end
      total++; if (busy !== 1'b1) $display("FAIL wr_busy: got %b want 1", busy); else passed++;
      bus_stop();
      total++; if (busy !== 1'b0) $display("FAIL wr_busy_stop: got %b want 0", busy); else passed++;
      total++; if (rx_cnt - base != n) $display("FAIL wr_rx_count: got %0d want %0d", rx_cnt - base, n); else passed++;
      for (int i = 0; i < n; i++) begin
        total++;
        if (rx_log[8'(base + i)] !== d[i]) $display("FAIL wr_rx_data: byte %0d got %h want %h", i, rx_log[8'(base + i)], d[i]);
        else passed++;
      end
    end
  endtask

  task automatic test_read();
    logic [7:0] exp_b [4];
    logic [7:0] got;
    int n, base;
    logic ack;
    for (int rep = 0; rep < 3; rep++) begin
      if (rep == 0) begin
        n = 2; exp_b[0] = 8'h5A; exp_b[1] = 8'hC3;
      end else begin
        n = int'($urandom_range(1, 3));
        for (int i = 0; i < 4; i++) exp_b[i] = 8'($urandom);
      end
      base = txr_cnt;
      for (int i = 0; i < 4; i++) tx_src[8'(base + i)] = exp_b[i];
      bus_start();
      write_byte({ADDR, 1'b1}, -1, ack);
      total++; if (ack !== 1'b1) $display("FAIL rd_addr_ack: got %b want 1", ack); else passed++;
      for (int i = 0; i < n; i++) begin
        read_byte(i == n - 1, got);
        total++; if (got !== exp_b[i]) $display("FAIL rd_data: byte %0d got %h want %h", i, got, exp_b[i]); else passed++;
      end
      total++; if (sda_oe !== 1'b0) $display("FAIL rd_nack_release: got %b want 0", sda_oe); else passed++;
      total++; if (txr_cnt - base != n) $display("FAIL rd_txreq_count: got %0d want %0d", txr_cnt - base, n); else passed++;
      bus_stop();
      total++; if (busy !== 1'b0) $display("FAIL rd_busy_stop: got %b want 0", busy); else passed++;
    end
  endtask

  task automatic test_mismatch();
    logic [6:0] a;
    logic [7:0] got;
    int rx0, tx0, oe0;
    logic ack;
    rx0 = rx_cnt; tx0 = txr_cnt; oe0 = oe_cnt;
    do a = 7'($urandom_range(1, 127)); while (a == ADDR);
    bus_start();
    write_byte({a, 1'b0}, -1, ack);
    total++; if (ack !== 1'b0) $display("FAIL mm_addr_ack: addr %h got %b want 0", a, ack); else passed++;
    for (int i = 0; i < 2; i++) begin
      write_byte(8'($urandom), -1, ack);
      total++; if (ack !== 1'b0) $display("FAIL mm_data_ack: got %b want 0", ack); else passed++;
    end
    total++; if (busy !== 1'b0) $display("FAIL mm_busy: got %b want 0", busy); else passed++;
    bus_stop();
    bus_start();
    write_byte({a, 1'b1}, -1, ack);
    read_byte(1'b1, got);
    total++; if (got !== 8'hFF) $display("FAIL mm_read_data: got %h want ff", got); else passed++;
    bus_stop();
    total++; if (oe_cnt != oe0) $display("FAIL mm_sda_oe: got %0d cycles want 0", oe_cnt - oe0); else passed++;
    total++; if (rx_cnt != rx0) $display("FAIL mm_rx_valid: got %0d want 0", rx_cnt - rx0); else passed++;
    total++; if (txr_cnt != tx0) $display("FAIL mm_tx_req: got %0d want 0", txr_cnt - tx0); else passed++;
  endtask

  task automatic test_repeated_start();
    logic [7:0] got, exp_b;
    int tx0;
    logic ack;
    exp_b = 8'($urandom);
    tx0 = txr_cnt;
    tx_src[8'(tx0)] = exp_b;
    bus_start();
    write_byte({ADDR, 1'b0}, -1, ack);
    write_byte(8'h01, -1, ack);
    total++; if (ack !== 1'b1) $display("FAIL rs_data_ack: got %b want 1", ack); else passed++;
    bus_start();
    write_byte({ADDR, 1'b1}, -1, ack);
    total++; if (ack !== 1'b1) $display("FAIL rs_addr_ack: got %b want 1", ack); else passed++;
    read_byte(1'b1, got);
    total++; if (got !== exp_b) $display("FAIL rs_read_data: got %h want %h", got, exp_b); else passed++;
    bus_stop();
    total++; if (rx_data !== 8'h01) $display("FAIL rs_rx_data: got %h want 01", rx_data); else passed++;
    total++; if (txr_cnt - tx0 != 1) $display("FAIL rs_tx_req: got %0d want 1", txr_cnt - tx0); else passed++;
    total++; if (busy !== 1'b0 || sda_oe !== 1'b0) $display("FAIL rs_idle: got busy=%b oe=%b want 0/0", busy, sda_oe); else passed++;
  endtask

  task automatic test_glitch_reset();
    logic [7:0] d;
    logic r, ack;
    int rx0, oe0;
    d = 8'($urandom);
    rx0 = rx_cnt;
    bus_start();
    write_byte({ADDR, 1'b0}, -1, ack);
    write_byte(d, 4, ack);
    bus_stop();
    total++; if (rx_cnt - rx0 != 1 || rx_log[8'(rx0)] !== d)
      $display("FAIL glitch_rx: got %0d bytes last %h want 1 byte %h", rx_cnt - rx0, rx_log[8'(rx0)], d);
    else passed++;
    bus_start();
    for (int i = 7; i >= 0; i--) clock_bit(ADDR[(i == 0) ? 0 : i - 1] & (i != 0), 1'b0, r);
    total++; if (sda_oe !== 1'b1) $display("FAIL rst_pre_ack: got %b want 1", sda_oe); else passed++;
    reset = 1'b1;
    wait_cyc(1);
    total++; if (sda_oe !== 1'b0) $display("FAIL rst_oe_release: got %b want 0", sda_oe); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else passed++;
    reset = 1'b0;
    rx0 = rx_cnt; oe0 = oe_cnt;
    clock_bit(1'b1, 1'b0, r);
    write_byte(8'($urandom), -1, ack);
    total++; if (rx_cnt != rx0) $display("FAIL rst_no_rx: got %0d want 0", rx_cnt - rx0); else passed++;
    total++; if (oe_cnt != oe0) $display("FAIL rst_no_oe: got %0d cycles want 0", oe_cnt - oe0); else passed++;
    bus_stop();
    d = 8'($urandom);
    bus_start();
    write_byte({ADDR, 1'b0}, -1, ack);
    write_byte(d, -1, ack);
    bus_stop();
    total++; if (rx_cnt - rx0 != 1 || rx_log[8'(rx0)] !== d)
      $display("FAIL rst_recover: got %0d bytes last %h want 1 byte %h", rx_cnt - rx0, rx_log[8'(rx0)], d);
    else passed++;
  endtask

  task automatic test_gencall();
    logic ack_a, ack_d;
    int rx0;
    rx0 = rx_cnt;
    bus_start();
    write_byte(8'h00, -1, ack_a);
    write_byte(8'h06, -1, ack_d);
    bus_stop();
`ifdef I2C_TARGET_GENCALL_EN
    total++; if (ack_a !== 1'b1 || ack_d !== 1'b1) $display("FAIL gc_ack: got %b%b want 11", ack_a, ack_d); else passed++;
    total++; if (rx_data !== 8'h06) $display("FAIL gc_rx_data: got %h want 06", rx_data); else passed++;
`else
    total++; if (ack_a !== 1'b0 || ack_d !== 1'b0) $display("FAIL gc_ack: got %b%b want 00", ack_a, ack_d); else passed++;
    total++; if (rx_cnt != rx0) $display("FAIL gc_rx: got %0d want 0", rx_cnt - rx0); else passed++;
`endif
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_mismatch();
    test_repeated_start();
    test_glitch_reset();
    test_gencall();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
